// File: rtl/tdr_scan_host.sv
// Single-TDR IJTAG scan host: one capture-shift-update sequence per request.
// Optional capture/readback path is built when TDR_SCAN_HOST_CAPTURE_EN is defined.
module tdr_scan_host #(
  parameter int TDR_LEN = 21
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [TDR_LEN-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [TDR_LEN-1:0] rsp_rdata,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so,
  output logic [2:0]         dbg_state
);

  // Handshakes: a request transfers on a posedge with req_valid & req_ready;
  // a response transfers on a posedge with rsp_valid & rsp_ready.

  localparam int CNT_W = $clog2(TDR_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TDR_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TDR_LEN-1:0] sout_q, sout_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               sel_q, sel_d;
  logic               se_q, se_d;
  logic               ue_q, ue_d;
  logic               si_q, si_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    case (state_q)
      IDLE: begin
        if (req_ready_q && req_valid) begin
          sout_d = req_wdata;
          cnt_d  = '0;
`ifdef TDR_SCAN_HOST_CAPTURE_EN
          state_d = CAPTURE;
`else
          state_d = SHIFT;
`endif
        end
      end
      CAPTURE: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        sout_d = sout_q >> 1;
        if (cnt_q == LAST_CNT) state_d = UPDATE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      UPDATE:  state_d = RESP;
      RESP:    if (rsp_valid_q && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every pin is a flop.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    sel_d       = (state_d == CAPTURE) || (state_d == SHIFT) || (state_d == UPDATE);
    se_d        = (state_d == SHIFT);
    ue_d        = (state_d == UPDATE);
    // si holds its last value outside SHIFT so it only moves while se is high.
    si_d        = se_d ? sout_d[0] : si_q;
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sout_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      sel_q       <= 1'b0;
      se_q        <= 1'b0;
      ue_q        <= 1'b0;
      si_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sout_q      <= sout_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      sel_q       <= sel_d;
      se_q        <= se_d;
      ue_q        <= ue_d;
      si_q        <= si_d;
    end
  end

`ifdef TDR_SCAN_HOST_CAPTURE_EN
  logic               ce_q, ce_d;
  logic [TDR_LEN-1:0] rdata_q, rdata_d;

  always_comb begin
    ce_d    = (state_d == CAPTURE);
    rdata_d = rdata_q;
    // ijtag_so is retimed at the target, so it is stable at this posedge.
    if (state_q == SHIFT) rdata_d = {ijtag_so, rdata_q[TDR_LEN-1:1]};
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      ce_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      ce_q    <= ce_d;
      rdata_q <= rdata_d;
    end
  end

  assign ijtag_ce  = ce_q;
  assign rsp_rdata = rdata_q;
`else
  logic unused_so;
  assign unused_so = ijtag_so;
  assign ijtag_ce  = 1'b0;
  assign rsp_rdata = '0;
`endif

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign ijtag_sel = sel_q;
  assign ijtag_se  = se_q;
  assign ijtag_ue  = ue_q;
  assign ijtag_si  = si_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tdr_scan_host.sv
// Directed bench for tdr_scan_host with a behavioural target TDR and an
// expected-response queue; works with TDR_SCAN_HOST_CAPTURE_EN defined or not.
module tb_tdr_scan_host;

  localparam int L = 21;
`ifdef TDR_SCAN_HOST_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         ijtag_reset;
  logic         req_valid;
  logic         req_ready;
  logic [L-1:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [L-1:0] rsp_rdata;
  logic         ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, ijtag_so;
  logic [2:0]   dbg_state;

  tdr_scan_host #(.TDR_LEN(L)) dut (
    .ijtag_tck   (clk),
    .ijtag_reset (ijtag_reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .ijtag_sel   (ijtag_sel),
    .ijtag_ce    (ijtag_ce),
    .ijtag_se    (ijtag_se),
    .ijtag_ue    (ijtag_ue),
    .ijtag_si    (ijtag_si),
    .ijtag_so    (ijtag_so),
    .dbg_state   (dbg_state)
  );

  // ---------------- target TDR model ----------------
  logic [L-1:0] tdr_sr  = '0;
  logic [L-1:0] tdr_img = '0;
  logic         tdr_so  = 1'b0;
  assign ijtag_so = tdr_so;

  always @(posedge clk) begin
    if (ijtag_sel && ijtag_ce)      tdr_sr <= tdr_img;
    else if (ijtag_sel && ijtag_se) tdr_sr <= {ijtag_si, tdr_sr[L-1:1]};
  end

  always @(negedge clk) begin
    tdr_so <= tdr_sr[0];
    if (ijtag_sel && ijtag_ue) tdr_img <= tdr_sr;
  end

  // ---------------- protocol monitor ----------------
  int           se_cnt = 0, ue_cnt = 0, ce_cnt = 0, proto_err = 0;
  logic         si_prev = 1'b0;
  logic         rst_d1 = 1'b1;
  logic [L-1:0] si_log = '0;

  always @(posedge clk) rst_d1 <= ijtag_reset;

  always @(negedge clk) begin
    if (rst_d1 == 1'b0) begin
      if (int'(ijtag_ce) + int'(ijtag_se) + int'(ijtag_ue) > 1) proto_err++;
      if (!ijtag_sel && (ijtag_ce || ijtag_se || ijtag_ue))      proto_err++;
      if ((ijtag_si !== si_prev) && !ijtag_se)                   proto_err++;
    end
    if (ijtag_se) begin
      se_cnt++;
      si_log = {ijtag_si, si_log[L-1:1]};
    end
    if (ijtag_ue) ue_cnt++;
    if (ijtag_ce) ce_cnt++;
    si_prev = ijtag_si;
  end

  // ---------------- scoreboard ----------------
  logic [L-1:0] exp_q[$];
  logic [L-1:0] cur_img = '0;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_wait", req_ready, 1'b1);
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [L-1:0] wdata, input int hold);
    int           lat, se0, ue0, ce0, se1;
    logic [L-1:0] held, exp;
    exp_q.push_back(CAP ? cur_img : '0);
    wait_ready();
    se0 = se_cnt;
    ue0 = ue_cnt;
    ce0 = ce_cnt;
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = L'($urandom);
    check("req_ready_busy", req_ready, 1'b0);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", lat, CAP ? L + 3 : L + 2);
    exp = exp_q.pop_front();
    check("rsp_rdata", rsp_rdata, exp);
    check("tdr_image", tdr_img, wdata);
    check("si_lsb_first", si_log, wdata);
    check("se_cycles", se_cnt - se0, L);
    check("ue_pulses", ue_cnt - ue0, 1);
    check("ce_pulses", ce_cnt - ce0, CAP ? 1 : 0);
    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      req_valid = i[0];
      req_wdata = ~wdata;
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1'b1);
      check("hold_rsp_rdata", rsp_rdata, held);
      check("hold_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid_drop", rsp_valid, 1'b0);
    check("req_ready_after", req_ready, 1'b1);
    se1 = se_cnt;
    repeat (3) @(negedge clk);
    check("no_queued_req", se_cnt - se1, 0);
    cur_img = wdata;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, t;
    ijtag_reset = 1'b1;
    req_valid   = 1'b0;
    req_wdata   = '0;
    rsp_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    check("rst_controls", {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}, 5'b0);
    ijtag_reset = 1'b0;
    @(negedge clk);
    check("req_ready_first", req_ready, 1'b1);

    send(21'h1ABCDE, 0);
    send(21'h000001, 0);
    send(L'($urandom_range(0, (1 << L) - 1)), 10);

    // Abort a write during SHIFT cycle 7.
    wait_ready();
    req_valid = 1'b1;
    req_wdata = 21'h0F0F0F;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    t = 0;
    while (t < 100) begin
      if (ijtag_se) begin
        if (n == 7) break;
        n++;
      end
      @(negedge clk);
      t++;
    end
    check("shift7_reached", n, 7);
    ijtag_reset = 1'b1;
    @(negedge clk);
    check("abort_controls", {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue}, 4'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_req_ready", req_ready, 1'b0);
    ijtag_reset = 1'b0;
    @(negedge clk);
    check("abort_ready_back", req_ready, 1'b1);
    check("abort_img_kept", tdr_img, cur_img);

    send(21'h155555, 0);
    send(21'h100000, 0);
    send(21'h000000, 0);

    check("protocol_errors", proto_err, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tdr_scan_host.md
# tdr_scan_host

Single-TDR IJTAG scan host: drives the `ijtag_sel/ce/se/ue/si` controls of one TDR on a dedicated segment and collects `ijtag_so`. It is the initiator counterpart of our generated TDRs, for example the intest EDT/SOL control register. It lets on-die logic (BIST sequencer, SOL calibration engine) write a new register image and read back the prior one without a tester-driven TAP. Each request runs a complete capture–shift–update sequence.

## Interface
- `TDR_LEN`, 21: length of the target TDR in bits; legal range 2..64.
- `ijtag_tck` in 1: single clock. All host flops are on the posedge. The same clock drives the target TDR.
- `ijtag_reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: host idle and able to accept a request.
- `req_wdata` in TDR_LEN: image to load; bit 0 is shifted first.
- `rsp_valid` out 1: transaction complete; held until `rsp_ready`.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out TDR_LEN: image captured from the TDR; bit 0 is the first bit out.
- `ijtag_sel` out 1: TDR select.
- `ijtag_ce` out 1: capture enable.
- `ijtag_se` out 1: shift enable.
- `ijtag_ue` out 1: update enable.
- `ijtag_si` out 1: scan data to the TDR.
- `ijtag_so` in 1: scan data from the TDR. It is negedge-retimed at the target, so it is stable at the posedge.

## Operation
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch `req_wdata` into the shift-out register and go to CAPTURE.
- **CAPTURE** (1 cycle)
  - `sel`=1, `ce`=1.
  - Then go to SHIFT with the counter at 0.
- **SHIFT** (exactly TDR_LEN cycles)
  - `sel`=1, `se`=1, `si` = shift-out register bit 0.
  - Each cycle: shift-out register shifts right; `rdata` <= {`ijtag_so`, `rdata[TDR_LEN-1:1]`}; counter increments.
  - After the count of TDR_LEN-1, go to UPDATE.
- **UPDATE** (1 cycle)
  - `sel`=1, `ue`=1. The target latches its image on the negedge within this cycle.
  - Then go to RESP.
- **RESP**
  - All IJTAG controls 0.
  - `rsp_valid`=1 and `rsp_rdata` stable until `rsp_valid`&`rsp_ready`, then go to IDLE.
- Only one transaction is in flight. `req_ready` is 0 in every state except IDLE.
- Counter width: $clog2(TDR_LEN). It never wraps, because the SHIFT exit occurs at TDR_LEN-1.
- `ijtag_sel` is continuous from CAPTURE through UPDATE, never more than one of `ce`/`se`/`ue` is 1, and all three are 0 whenever `sel`=0.

## Timing
- All outputs are registered; no combinational paths from input to output.
- Reset values: `req_ready`=0 during reset and 1 on the first cycle after; `rsp_valid`=0; `rsp_rdata`=0; `ijtag_sel`/`ce`/`se`/`ue`/`si`=0.
- Latency, with capture compiled in:
  - Accept edge → CAPTURE: 1 cycle.
  - CAPTURE + SHIFT + UPDATE: TDR_LEN+2 cycles.
  - `rsp_valid` rises TDR_LEN+3 cycles after the accept edge.
- `ijtag_so` sampling: at the posedge ending each SHIFT cycle. The value seen is TDR bit 0 from before that edge's shift.
- `rsp_ready` already high when RESP is entered: RESP lasts 1 cycle. The next `req_ready` follows 1 cycle after that, so there is no same-cycle re-accept.
- Reset mid-transaction:
  - FSM returns to IDLE and all controls drop to 0 at that edge.
  - `ue` has not been pulsed, so the TDR update latches keep their old image.
  - The partial response is discarded.
- `req_valid` while busy is ignored and is not queued.

## Configuration
- `TDR_SCAN_HOST_CAPTURE_EN` defined:
  - CAPTURE state is present.
  - `rsp_rdata` returns the image captured before the write.
- Undefined:
  - CAPTURE state is removed; IDLE goes directly to SHIFT.
  - `ijtag_ce` is tied 0 and `rsp_rdata` is tied 0; the `rdata` register is not built.
  - Latency is TDR_LEN+2 cycles.
  - The target then shifts its stale shift-register contents, which the host ignores.

## Test plan
- Reset, then write `21'h1ABCDE` into a target TDR model holding reset state → `rsp_rdata`=0, target outputs = `21'h1ABCDE` after UPDATE, `rsp_valid` at accept+24.
- Second write of `21'h000001` → `rsp_rdata`=`21'h1ABCDE`, target image = `21'h000001`. Assert exactly 21 `se` cycles and one `ue` pulse.
- Hold `rsp_ready`=0 for 10 cycles → `rsp_valid`/`rsp_rdata` stable; `req_valid` pulsed during the wait is not accepted; `req_ready`=0.
- Assert `ijtag_reset` on SHIFT cycle 7 → controls 0 on the next cycle, target image unchanged, next request completes normally.
- Walking-one image `21'h100000` with `TDR_LEN`=21, then with the macro undefined → capture/update timing and LSB-first order correct; `ce` never asserted and latency 23 without the macro.
- Protocol checker throughout: `ce`/`se`/`ue` one-hot-or-zero, never asserted with `sel`=0, `si` changes only while `se`=1.
